// File: rtl/formula_pipeline_if.sv
// Streaming operand/result bundle for formula_pipeline.
// master = operand source and result consumer, slave = the datapath.
interface formula_pipeline_if #(
  parameter int width = 8
);
  localparam int width_out = 2 * width + 6;

  logic                        vld_in;
  logic signed [width-1:0]     a;
  logic signed [width-1:0]     b;
  logic signed [width-1:0]     c;
  logic signed [width-1:0]     d;
  logic                        vld_out;
  logic signed [width_out-1:0] q;

  modport master (
    output vld_in, a, b, c, d,
    input  vld_out, q
  );

  modport slave (
    input  vld_in, a, b, c, d,
    output vld_out, q
  );
endinterface

// File: rtl/formula_pipeline.sv
// Three-stage signed pipeline computing q = 8*(a-b)*(c+d) + a*b at full precision.
// One operand set per clock, no backpressure; data stages only load behind a valid bit.
module formula_pipeline #(
  parameter int width = 8
) (
  input  logic              clk,
  input  logic              rst,
  formula_pipeline_if.slave io
);
  localparam int width_out = 2 * width + 6;
  localparam int dw        = width + 1;      // a-b, c+d
  localparam int pw        = 2 * width;      // a*b
  localparam int mw        = 2 * width + 2;  // (a-b)*(c+d)

  // Stage 1
  logic signed [dw-1:0]        diff_d, diff_q;
  logic signed [dw-1:0]        sum_d, sum_q;
  logic signed [pw-1:0]        pab1_d, pab1_q;
  logic                        v1_d, v1_q;
  // Stage 2
  logic signed [mw-1:0]        prod_d, prod_q;
  logic signed [pw-1:0]        pab2_d, pab2_q;
  logic                        v2_d, v2_q;
  // Stage 3
  logic signed [width_out-1:0] q_d, q_q;
  logic                        vld_d, vld_q;

  // NOTE: every signal is given its hold value before the enables, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    diff_d = diff_q;
    sum_d  = sum_q;
    pab1_d = pab1_q;
    prod_d = prod_q;
    pab2_d = pab2_q;
    q_d    = q_q;
    v1_d   = io.vld_in;
    v2_d   = v1_q;
    vld_d  = v2_q;

    // Size casts on signed operands sign-extend before each operation, keeping every step exact.
    if (io.vld_in) begin
      diff_d = dw'(io.a) - dw'(io.b);
      sum_d  = dw'(io.c) + dw'(io.d);
      pab1_d = pw'(io.a) * pw'(io.b);
    end
    if (v1_q) begin
      prod_d = mw'(diff_q) * mw'(sum_q);
      pab2_d = pab1_q;
    end
    if (v2_q) begin
      q_d = (width_out'(prod_q) <<< 3) + width_out'(pab2_q);
    end
  end

  // NOTE: state updates use non-blocking assignments so all stages advance together on the same edge.
  // NOTE: every register, data included, clears on reset so q reads 0 and never X before the first result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff_q <= '0;
      sum_q  <= '0;
      pab1_q <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      pab2_q <= '0;
      v2_q   <= 1'b0;
      q_q    <= '0;
      vld_q  <= 1'b0;
    end else begin
      diff_q <= diff_d;
      sum_q  <= sum_d;
      pab1_q <= pab1_d;
      v1_q   <= v1_d;
      prod_q <= prod_d;
      pab2_q <= pab2_d;
      v2_q   <= v2_d;
      q_q    <= q_d;
      vld_q  <= vld_d;
    end
  end

  assign io.vld_out = vld_q;
  assign io.q       = q_q;
endmodule

// File: tb/tb_formula_pipeline.sv
// Directed and random checks of formula_pipeline against hand-computed values and a
// 3-cycle delay-line reference of 8*(a-b)*(c+d) + a*b.
module tb_formula_pipeline;
  localparam int width = 8;

  logic clk;
  logic rst;

  formula_pipeline_if #(.width(width)) io ();

  formula_pipeline #(.width(width)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference delay line: two in-flight slots plus the visible output.
  logic   p1_v, p2_v, exp_v;
  longint p1_r, p2_r, exp_q;

  task automatic check(input string tag, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic longint ref_q(input int a, input int b, input int c, input int d);
    return 64'(8 * (a - b) * (c + d) + a * b);
  endfunction

  task automatic clear_model();
    p1_v = 1'b0; p2_v = 1'b0; exp_v = 1'b0;
    p1_r = 0;    p2_r = 0;    exp_q = 0;
  endtask

  // One clock: advance the model with what the DUT samples, then compare just after the edge.
  task automatic tick();
    logic   cv;
    longint cr;
    cv = io.vld_in;
    cr = ref_q(int'(io.a), int'(io.b), int'(io.c), int'(io.d));
    @(posedge clk);
    if (!rst) begin
      clear_model();
    end else begin
      if (p2_v) exp_q = p2_r;
      exp_v = p2_v;
      p2_v  = p1_v;
      p2_r  = p1_r;
      p1_v  = cv;
      p1_r  = cr;
    end
    #1;
    check("model_vld", longint'(io.vld_out), longint'(exp_v));
    check("model_q", longint'(io.q), exp_q);
  endtask

  // Operands are random junk when v=0, proving idle cycles do not disturb the data path.
  task automatic apply(input logic v, input int a, input int b, input int c, input int d);
    io.vld_in = v;
    if (v) begin
      io.a = 8'(a); io.b = 8'(b); io.c = 8'(c); io.d = 8'(d);
    end else begin
      io.a = 8'($urandom); io.b = 8'($urandom); io.c = 8'($urandom); io.d = 8'($urandom);
    end
    tick();
  endtask

  int     va[5] = '{3, -1, 0, -128, 127};
  int     vb[5] = '{1, -1, 0, 127, -128};
  int     vc[5] = '{2, 0, 0, -128, -128};
  int     vd[5] = '{4, 0, 0, -128, -128};
  longint vq[5] = '{99, 1, 0, 505984, -538496};

  initial begin
    clear_model();
    rst       = 1'b0;
    io.vld_in = 1'b0;
    io.a = '0; io.b = '0; io.c = '0; io.d = '0;

    // Reset held with random, valid-qualified inputs: outputs must stay clear.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      check("reset_vld", longint'(io.vld_out), 0);
      check("reset_q", longint'(io.q), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply(1'b0, 0, 0, 0, 0);

    // Five back-to-back sets, each result exactly 3 cycles after its input, in order.
    for (int i = 0; i < 8; i++) begin
      if (i < 5) apply(1'b1, va[i], vb[i], vc[i], vd[i]);
      else       apply(1'b0, 0, 0, 0, 0);
      if (i >= 2 && i < 7) begin
        check("stream_vld", longint'(io.vld_out), 1);
        check("stream_q", longint'(io.q), vq[i-2]);
      end else if (i == 7) begin
        check("stream_end_vld", longint'(io.vld_out), 0);
        check("stream_hold_q", longint'(io.q), -538496);
      end
    end

    // Gap pattern 1,0,1: q holds the first result through the gap.
    apply(1'b1, 3, 1, 2, 4);
    apply(1'b0, 0, 0, 0, 0);
    apply(1'b1, 127, -128, -128, -128);
    check("gap_v0", longint'(io.vld_out), 1);
    check("gap_q0", longint'(io.q), 99);
    apply(1'b0, 0, 0, 0, 0);
    check("gap_v1", longint'(io.vld_out), 0);
    check("gap_q1", longint'(io.q), 99);
    apply(1'b0, 0, 0, 0, 0);
    check("gap_v2", longint'(io.vld_out), 1);
    check("gap_q2", longint'(io.q), -538496);

    // Random regression with an asynchronous reset mid-stream.
    for (int i = 0; i < 70; i++) begin
      if (i == 35) begin
        rst = 1'b0;
        #1;
        check("async_rst_vld", longint'(io.vld_out), 0);
        check("async_rst_q", longint'(io.q), 0);
        clear_model();
        apply(1'b1, 5, 6, 7, 8);
        apply(1'b1, 9, 10, 11, 12);
        rst = 1'b1;
      end
      apply(($urandom_range(0, 9) < 8), int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128);
    end
    for (int i = 0; i < 4; i++) apply(1'b0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
